rob: RTL
========

Name: rob

Overview:
Reorder buffer of the Tomasulo RISC-V core.
- Sits between issue/CDB and the register file.
- Allocates a tag (robpos) per issued instruction; issue hands that tag to the regfile as lock_robpos.
- Collects results from the ALU and LSB broadcast ports and retires one entry per cycle in program order.
- Drives the regfile unlock port, triggers store execution in the LSB, and raises a pipeline flush on branch mispredict.

Parameters:
ROB_SIZE, 32, entry count; must equal 2^width of `ROB_LEN (5 bits).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ready  in  1  global stall: state frozen when low
issue_valid  in  1  allocate entry this cycle
issue_type  in  2  `ROB_REG / `ROB_ST / `ROB_BR
issue_rd  in  `REG_LEN  destination register (x0 is never passed as writable)
issue_has_rd  in  1  entry writes rd on commit (REG, or BR for JAL/JALR)
issue_pred_jump  in  1  predicted taken
issue_pc  in  `ADDR_LEN  fallthrough PC, used on not-taken mispredict
rob_full  out  1  no free entry
rob_tail  out  `ROB_LEN  tag to be allocated this cycle
q1_pos, q2_pos  in  `ROB_LEN  operand tags to probe
q1_ready, q2_ready  out  1  probed entry value available
q1_val, q2_val  out  `DATA_LEN  probed value
alu_valid  in  1  ALU result broadcast
alu_robpos  in  `ROB_LEN  ALU result tag
alu_val  in  `DATA_LEN  ALU result value
alu_jump  in  1  resolved branch taken
alu_target  in  `ADDR_LEN  resolved branch target
lsb_valid  in  1  LSB result broadcast
lsb_robpos  in  `ROB_LEN  LSB result tag
lsb_val  in  `DATA_LEN  LSB result value
commit_reg  out  1  regfile unlock strobe
commit_rd  out  `REG_LEN  register to unlock
commit_robpos  out  `ROB_LEN  tag being retired
commit_val  out  `DATA_LEN  value written to register
commit_store  out  1  store at commit_robpos may now write memory
flush  out  1  mispredict; all speculative state dies
flush_pc  out  `ADDR_LEN  refetch PC

Behaviour:
- Storage
  - Circular buffer, head/tail pointers of width `ROB_LEN, plus a count register of width `ROB_LEN+1.
  - Per entry: busy, done, type, has_rd, rd, val, pred_jump, real_jump, target, pc.
- Reset
  - head = tail = count = 0; all busy = done = 0.
  - All registered outputs 0: commit_*, flush, flush_pc.
- Stall
  - ready low: no pointer, count, or entry change.
  - Registered pulse outputs drop to 0 on the next edge.
- Full and tail
  - rob_full = (count == ROB_SIZE), combinational; rob_tail = tail.
- Issue
  - Fires on issue_valid && !rob_full && ready.
  - Writes entry[tail]: busy=1, done = (type==`ROB_ST), other fields from issue_*; tail++ with wrap 31->0.
  - Stores become done at issue; address/data readiness is the LSB's concern.
  - issue_valid while full is ignored, not queued.
- Writeback
  - alu_valid/lsb_valid with a busy target entry: set done=1 and val.
  - ALU writeback also sets real_jump and target.
  - Writeback to a non-busy entry is ignored.
  - Both ports may hit different entries in the same cycle.
- Commit
  - At most one per cycle; fires when entry[head].busy && entry[head].done, evaluated on registered state.
  - Writeback arriving this cycle commits next cycle at the earliest. Commit latency after writeback is 1 cycle.
  - Outputs are registered; each pulse is 1 cycle.
  - commit_reg = has_rd, carrying rd, val and head.
  - commit_store = (type==`ROB_ST).
  - Clear busy; head++; count--.
- Mispredict
  - Condition: a BR entry commits with real_jump != pred_jump.
  - flush=1 for one cycle; flush_pc = real_jump ? target : pc.
  - Rd write-back of that branch still happens in the same cycle.
  - On the same edge: head = tail = count = 0, all busy cleared.
  - Issue in that cycle is discarded.
- Simultaneous issue + commit
  - count unchanged; full was evaluated before commit, so issue stays blocked while full.
- Probe ports (combinational)
  - q_ready=1 if entry done.
  - Else if alu_valid and alu_robpos==q_pos: bypass alu_val.
  - Else if lsb_valid and lsb_robpos==q_pos: bypass lsb_val.
  - Else q_ready=0, q_val=0.
- Reset mid-operation
  - Wins over everything: flush, commit and issue in that cycle have no effect.

Decomposition:
- def.v (shared): `ROB_LEN [4:0], `ROB_SIZ 32, `DATA_LEN, `ADDR_LEN, `REG_LEN, type codes `ROB_REG 2'd0, `ROB_ST 2'd1, `ROB_BR 2'd2.
- One sub-module, rob_probe: the combinational done/bypass mux, instantiated twice for q1 and q2.

Test Plan:
- Reset, then issue REG rd=5; ALU writes tag0 val=0x1234 -> next cycle commit_reg=1, commit_rd=5, commit_robpos=0, commit_val=0x1234; count back to 0.
- Issue 32 entries -> rob_full=1, rob_tail=0.
  - 33rd issue is ignored.
  - Complete tag0 -> commit; next cycle rob_full=0; a new issue gets tag0 (wrap-around).
- Issue tags 0,1; complete tag1 first (0xAA) and then tag0 (0xBB) -> commits in order: tag0=0xBB, then tag1=0xAA.
- Issue BR pred_jump=0, pc=0x100, then 3 REG entries; ALU resolves tag0 jump=1, target=0x200 -> flush=1, flush_pc=0x200; next cycle head=tail=count=0, no commit of tags 1-3.
- Probe q1_pos=2 while tag2 busy, not done, with alu_valid on tag2 (0x55) that cycle -> q1_ready=1, q1_val=0x55; without broadcast -> q1_ready=0.
- Issue ST at tag0, ready held low 3 cycles -> no commit_store. Raise ready -> commit_store=1 with commit_robpos=0 one cycle later.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared widths and entry-type codes for the reorder buffer.
package rob_pkg;

  localparam int ROB_LEN  = 5;
  localparam int ROB_SIZE = 1 << ROB_LEN;
  localparam int DATA_LEN = 32;
  localparam int ADDR_LEN = 32;
  localparam int REG_LEN  = 5;

  typedef logic [ROB_LEN-1:0]  robpos_t;
  typedef logic [DATA_LEN-1:0] data_t;
  typedef logic [ADDR_LEN-1:0] addr_t;
  typedef logic [REG_LEN-1:0]  reg_t;

  typedef enum logic [1:0] {
    ROB_REG = 2'd0,
    ROB_ST  = 2'd1,
    ROB_BR  = 2'd2
  } rob_type_e;

endpackage

// File: rtl/rob_if.sv
// Issue, probe, broadcast and retire signals of the reorder buffer.
interface rob_if;
  import rob_pkg::*;

  logic      issue_valid;
  rob_type_e issue_type;
  reg_t      issue_rd;
  logic      issue_has_rd;
  logic      issue_pred_jump;
  addr_t     issue_pc;
  logic      rob_full;
  robpos_t   rob_tail;

  robpos_t   q1_pos;
  robpos_t   q2_pos;
  logic      q1_ready;
  logic      q2_ready;
  data_t     q1_val;
  data_t     q2_val;

  logic      alu_valid;
  robpos_t   alu_robpos;
  data_t     alu_val;
  logic      alu_jump;
  addr_t     alu_target;
  logic      lsb_valid;
  robpos_t   lsb_robpos;
  data_t     lsb_val;

  logic      commit_reg;
  reg_t      commit_rd;
  robpos_t   commit_robpos;
  data_t     commit_val;
  logic      commit_store;
  logic      flush;
  addr_t     flush_pc;

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_has_rd, issue_pred_jump, issue_pc,
    output rob_full, rob_tail,
    input  q1_pos, q2_pos,
    output q1_ready, q2_ready, q1_val, q2_val,
    input  alu_valid, alu_robpos, alu_val, alu_jump, alu_target,
    input  lsb_valid, lsb_robpos, lsb_val,
    output commit_reg, commit_rd, commit_robpos, commit_val, commit_store, flush, flush_pc
  );

  modport master (
    output issue_valid, issue_type, issue_rd, issue_has_rd, issue_pred_jump, issue_pc,
    input  rob_full, rob_tail,
    output q1_pos, q2_pos,
    input  q1_ready, q2_ready, q1_val, q2_val,
    output alu_valid, alu_robpos, alu_val, alu_jump, alu_target,
    output lsb_valid, lsb_robpos, lsb_val,
    input  commit_reg, commit_rd, commit_robpos, commit_val, commit_store, flush, flush_pc
  );

endinterface

// File: rtl/rob_probe.sv
// Operand probe: stored value if the entry is done, else a same-cycle CDB bypass.
module rob_probe
  import rob_pkg::*;
(
  input  robpos_t pos,
  input  logic    entry_done,
  input  data_t   entry_val,
  input  logic    alu_valid,
  input  robpos_t alu_robpos,
  input  data_t   alu_val,
  input  logic    lsb_valid,
  input  robpos_t lsb_robpos,
  input  data_t   lsb_val,
  output logic    q_ready,
  output data_t   q_val
);

  always_comb begin
    q_ready = 1'b0;
    q_val   = '0;
    if (entry_done) begin
      q_ready = 1'b1;
      q_val   = entry_val;
    end else if (alu_valid && alu_robpos == pos) begin
      q_ready = 1'b1;
      q_val   = alu_val;
    end else if (lsb_valid && lsb_robpos == pos) begin
      q_ready = 1'b1;
      q_val   = lsb_val;
    end
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: allocates tags at issue, collects CDB results and retires in
// program order, one entry per cycle, flushing on branch mispredict.
module rob
  import rob_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic ready,
  rob_if.slave bus
);

  localparam logic [ROB_LEN:0] FULL_COUNT = (ROB_LEN+1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0] busy_reg;
  logic [ROB_SIZE-1:0] done_reg;
  rob_type_e           type_mem   [ROB_SIZE];
  logic                has_rd_mem [ROB_SIZE];
  reg_t                rd_mem     [ROB_SIZE];
  data_t               val_mem    [ROB_SIZE];
  logic                pred_mem   [ROB_SIZE];
  logic                real_mem   [ROB_SIZE];
  addr_t               target_mem [ROB_SIZE];
  addr_t               pc_mem     [ROB_SIZE];

  robpos_t          head_reg;
  robpos_t          tail_reg;
  logic [ROB_LEN:0] count_reg;

  logic    commit_reg_reg;
  reg_t    commit_rd_reg;
  robpos_t commit_robpos_reg;
  data_t   commit_val_reg;
  logic    commit_store_reg;
  logic    flush_reg;
  addr_t   flush_pc_reg;

  logic rob_full;
  logic issue_fire;
  logic commit_fire;
  logic mispredict;
  logic alu_hit;
  logic lsb_hit;

  assign rob_full    = (count_reg == FULL_COUNT);
  assign issue_fire  = bus.issue_valid && !rob_full && ready;
  // Commit looks only at registered state, so a result broadcast this cycle retires next cycle.
  assign commit_fire = ready && busy_reg[head_reg] && done_reg[head_reg];
  assign mispredict  = commit_fire && (type_mem[head_reg] == ROB_BR) &&
                       (real_mem[head_reg] != pred_mem[head_reg]);
  assign alu_hit     = bus.alu_valid && busy_reg[bus.alu_robpos];
  assign lsb_hit     = bus.lsb_valid && busy_reg[bus.lsb_robpos];

  // Entry payload carries no reset; busy/done decide whether it means anything.
  always_ff @(posedge clk) begin
    if (ready) begin
      if (issue_fire) begin
        type_mem[tail_reg]   <= bus.issue_type;
        has_rd_mem[tail_reg] <= bus.issue_has_rd;
        rd_mem[tail_reg]     <= bus.issue_rd;
        pred_mem[tail_reg]   <= bus.issue_pred_jump;
        pc_mem[tail_reg]     <= bus.issue_pc;
      end
      if (alu_hit) begin
        val_mem[bus.alu_robpos]    <= bus.alu_val;
        real_mem[bus.alu_robpos]   <= bus.alu_jump;
        target_mem[bus.alu_robpos] <= bus.alu_target;
      end
      if (lsb_hit) begin
        val_mem[bus.lsb_robpos] <= bus.lsb_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg          <= '0;
      tail_reg          <= '0;
      count_reg         <= '0;
      busy_reg          <= '0;
      done_reg          <= '0;
      commit_reg_reg    <= 1'b0;
      commit_rd_reg     <= '0;
      commit_robpos_reg <= '0;
      commit_val_reg    <= '0;
      commit_store_reg  <= 1'b0;
      flush_reg         <= 1'b0;
      flush_pc_reg      <= '0;
    end else begin
      commit_reg_reg   <= 1'b0;
      commit_store_reg <= 1'b0;
      flush_reg        <= 1'b0;
      if (ready) begin
        if (alu_hit) done_reg[bus.alu_robpos] <= 1'b1;
        if (lsb_hit) done_reg[bus.lsb_robpos] <= 1'b1;
        if (issue_fire) begin
          busy_reg[tail_reg] <= 1'b1;
          done_reg[tail_reg] <= (bus.issue_type == ROB_ST);
        end
        if (commit_fire) begin
          busy_reg[head_reg] <= 1'b0;
          commit_reg_reg     <= has_rd_mem[head_reg];
          commit_rd_reg      <= rd_mem[head_reg];
          commit_robpos_reg  <= head_reg;
          commit_val_reg     <= val_mem[head_reg];
          commit_store_reg   <= (type_mem[head_reg] == ROB_ST);
        end
        // Later assignments override the per-entry updates above, discarding any same-cycle issue.
        if (mispredict) begin
          flush_reg    <= 1'b1;
          flush_pc_reg <= real_mem[head_reg] ? target_mem[head_reg] : pc_mem[head_reg];
          head_reg     <= '0;
          tail_reg     <= '0;
          count_reg    <= '0;
          busy_reg     <= '0;
          done_reg     <= '0;
        end else begin
          head_reg  <= head_reg + robpos_t'(commit_fire);
          tail_reg  <= tail_reg + robpos_t'(issue_fire);
          count_reg <= count_reg + (ROB_LEN+1)'(issue_fire) - (ROB_LEN+1)'(commit_fire);
        end
      end
    end
  end

  rob_probe u_probe_q1 (
    .pos        (bus.q1_pos),
    .entry_done (done_reg[bus.q1_pos]),
    .entry_val  (val_mem[bus.q1_pos]),
    .alu_valid  (bus.alu_valid),
    .alu_robpos (bus.alu_robpos),
    .alu_val    (bus.alu_val),
    .lsb_valid  (bus.lsb_valid),
    .lsb_robpos (bus.lsb_robpos),
    .lsb_val    (bus.lsb_val),
    .q_ready    (bus.q1_ready),
    .q_val      (bus.q1_val)
  );

  rob_probe u_probe_q2 (
    .pos        (bus.q2_pos),
    .entry_done (done_reg[bus.q2_pos]),
    .entry_val  (val_mem[bus.q2_pos]),
    .alu_valid  (bus.alu_valid),
    .alu_robpos (bus.alu_robpos),
    .alu_val    (bus.alu_val),
    .lsb_valid  (bus.lsb_valid),
    .lsb_robpos (bus.lsb_robpos),
    .lsb_val    (bus.lsb_val),
    .q_ready    (bus.q2_ready),
    .q_val      (bus.q2_val)
  );

  assign bus.rob_full      = rob_full;
  assign bus.rob_tail      = tail_reg;
  assign bus.commit_reg    = commit_reg_reg;
  assign bus.commit_rd     = commit_rd_reg;
  assign bus.commit_robpos = commit_robpos_reg;
  assign bus.commit_val    = commit_val_reg;
  assign bus.commit_store  = commit_store_reg;
  assign bus.flush         = flush_reg;
  assign bus.flush_pc      = flush_pc_reg;

endmodule
